// File: rtl/flopr_pipe.sv
// Parametrised pipeline delay register: DEPTH resettable N-bit stages with valid
// tags, common advance enable, synchronous flush and a registered valid count.

module flopr_stage #(
  parameter int N          = 32,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         flush,
  input  logic [N-1:0] d,
  input  logic         d_valid,
  output logic [N-1:0] q,
  output logic         q_valid
);
  always_ff @(posedge clk) begin
    if (reset) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else if (flush) begin
      q_valid <= 1'b0;
      if (CLEAR_DATA) q <= '0;
    end else if (en) begin
      q       <= d;
      q_valid <= d_valid;
    end
  end
endmodule

module flopr_pipe #(
  parameter int N          = 32,
  parameter int DEPTH      = 4,
  parameter bit CLEAR_DATA = 1'b1,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          flush,
  input  logic [N-1:0]  d,
  input  logic          d_valid,
  output logic [N-1:0]  q,
  output logic          q_valid,
  output logic [CW-1:0] count
);
  // Index 0 is the input port; indices 1..DEPTH are the registered stages.
  logic [DEPTH:0][N-1:0] data_pipe;
  logic [DEPTH:0]        vld_pipe;
  logic [DEPTH-1:0]      vld_nxt;
  logic [CW-1:0]         cnt_nxt;

  assign data_pipe[0] = d;
  assign vld_pipe[0]  = d_valid;

  generate
    for (genvar i = 1; i <= DEPTH; i++) begin : g_stage
      flopr_stage #(.N(N), .CLEAR_DATA(CLEAR_DATA)) u_stage (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .flush   (flush),
        .d       (data_pipe[i-1]),
        .d_valid (vld_pipe[i-1]),
        .q       (data_pipe[i]),
        .q_valid (vld_pipe[i])
      );
    end
  endgenerate

  // Count tracks the next-state valid vector so it lands on the same edge.
  always_comb begin
    vld_nxt = vld_pipe[DEPTH:1];
    if (reset || flush) vld_nxt = '0;
    else if (en)        vld_nxt = vld_pipe[DEPTH-1:0];
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) cnt_nxt = cnt_nxt + CW'(vld_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else       count <= cnt_nxt;
  end

  assign q       = data_pipe[DEPTH];
  assign q_valid = vld_pipe[DEPTH];
endmodule

// File: doc/flopr_pipe.md
# flopr_pipe

Parametrised pipeline delay register: a chain of DEPTH resettable N-bit registers with per-stage valid bits, a common advance enable (stall when low), and a synchronous flush. It generalises the single resettable flip-flop used between datapath stages. Uses include inter-stage pipeline registers for the pipelined processor (stall/flush from the hazard unit) and fixed-latency alignment of side-band data against multi-cycle units.

## Interface
Parameters:
- N, 32: data width in bits, N ≥ 1.
- DEPTH, 4: number of register stages, DEPTH ≥ 1.
- CLEAR_DATA, 1: 1 means flush zeroes stage data as well as valid bits; 0 means flush clears valid bits only.

Ports:
- clk, input, 1: clock, rising-edge.
- reset, input, 1: reset, synchronous, active-high.
- en, input, 1: advance enable; 0 means stall (hold all stages).
- flush, input, 1: synchronous clear of all stages.
- d, input, N: data into stage 0.
- d_valid, input, 1: valid tag for d.
- q, output, N: data of stage DEPTH-1.
- q_valid, output, 1: valid bit of stage DEPTH-1.
- count, output, $clog2(DEPTH+1): number of stages currently holding valid = 1.

## Operation
- State per stage i in 0..DEPTH-1: data[i] (N bits) and valid[i] (1 bit). Also a registered count.
- Priority at each rising clk edge: reset, then flush, then en, then hold.
- reset = 1: all data[i] = 0, all valid[i] = 0, count = 0. This applies regardless of en, flush or d.
- flush = 1 (reset = 0):
  - All valid[i] = 0 and count = 0.
  - If CLEAR_DATA = 1, all data[i] = 0. Otherwise data[i] keeps its value.
  - The d/d_valid presented in that cycle is discarded, whatever the value of en.
- en = 1 (no reset, no flush):
  - data[0] = d and valid[0] = d_valid.
  - For i ≥ 1: data[i] = data[i-1] and valid[i] = valid[i-1].
  - Data is captured even when d_valid = 0, so bubbles carry whatever d held.
  - The entry in the last stage is dropped.
- en = 0: every data[i], valid[i] and count holds.
- count is the registered population count of the next-state valid vector, so it always equals popcount(valid) in the same cycle. It updates on the same edge as the stages, not one cycle later.
- Range of count: 0..DEPTH. At DEPTH = 4 with all stages valid, count = 4, and the width of 3 holds the value without wrap.
- DEPTH = 1 behaves as an N-bit flopr with enable, flush and a valid tag.
- No combinational path from any input to any output.

## Timing
- Output reset values: q = 0, q_valid = 0, count = 0, all on the first rising edge with reset = 1.
- Latency: a word accepted at edge k (en = 1) appears on q after edge k+DEPTH-1, provided en = 1 on each intervening edge. Each en = 0 edge adds one cycle.
- Throughput: one word per cycle while en = 1.
- Reset mid-stream: all in-flight data is lost. Output is 0 from the edge where reset is sampled high. With en = 1 and reset = 0, the first new word reaches q DEPTH edges after reset deasserts.
- flush and en both high: flush wins. Stage 0 is not loaded in that cycle.
- After a flush, q_valid stays 0 for at least DEPTH edges with en = 1, unless valid data has been re-injected.
- Outputs change only just after a rising clk edge. A bench should sample them no earlier than 1 ns after the edge.

## Test plan
All scenarios use N = 32, DEPTH = 4.
- **Reset:** hold reset = 1 for 5 cycles with d = 32'hDEADBEEF, d_valid = 1, en = 1. Required: q = 0, q_valid = 0, count = 0 on every cycle.
- **Streaming:** en = 1, d_valid = 1, feed 10 $random words W0..W9. Required: q = Wk and q_valid = 1 four edges after Wk is applied. count reads 1, 2, 3, 4, then stays at 4.
- **Stall:** while streaming, hold en = 0 for 3 cycles. Required: q, q_valid and count frozen. When en returns, the sequence resumes with no word lost or duplicated.
- **Flush:** fill 4 valid words, then pulse flush = 1 with en = 1 and d = 32'h12345678.
  - CLEAR_DATA = 1: next cycle q = 0, q_valid = 0, count = 0, and 12345678 never appears on q.
  - CLEAR_DATA = 0: same valid and count result, and q retains the old stage-3 data.
- **Bubbles:** alternate d_valid = 1/0 with d = 1, 2, 3, 4. Required: q_valid pattern 1, 0, 1, 0 delayed by 4 edges, and count toggles between 2 and 2 at steady state.
- **Reset priority:** assert reset and flush together mid-stream. Required: all outputs 0. Then release and feed 32'hA5A5A5A5 with valid. Required: it appears on q four edges after release.
